// File: rtl/ok_wire_pkg.sv
// Shared constants for the host wire-in endpoint bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ok_wire_pkg;

  localparam logic [7:0] OK_WIREIN_ADDR_FIRST = 8'h00;
  localparam logic [7:0] OK_WIREIN_ADDR_LAST  = 8'h1F;

  localparam int OK_DATA_W = 32;
  localparam int OK_ADDR_W = 8;

  localparam int OK_UPD_STROBE    = 0;
  localparam int OK_UPD_IMMEDIATE = 1;

endpackage

// File: rtl/ok_wire_in_bank_if.sv
// Host wire-in bus plus the per-channel user-side outputs of the bank.
// Latency: n/a (signal bundle).
// Backpressure: none; host strobes are single-cycle and always accepted.
interface ok_wire_in_bank_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
);
  import ok_wire_pkg::*;

  logic                  ti_write;
  logic [OK_ADDR_W-1:0]  ti_addr;
  logic [OK_DATA_W-1:0]  ti_datain;
  logic                  ti_wireupdate;
  logic                  clr_overwrite;
  logic [N_CH*WIDTH-1:0] ep_dataout;
  logic [N_CH-1:0]       ep_changed;
  logic [N_CH-1:0]       ep_pending;
  logic [N_CH-1:0]       ep_overwrite;

  // Host side: drives strobes, observes channel state.
  modport master (
    output ti_write, ti_addr, ti_datain, ti_wireupdate, clr_overwrite,
    input  ep_dataout, ep_changed, ep_pending, ep_overwrite
  );

  // Bank side.
  modport slave (
    input  ti_write, ti_addr, ti_datain, ti_wireupdate, clr_overwrite,
    output ep_dataout, ep_changed, ep_pending, ep_overwrite
  );

endinterface

// File: rtl/ok_wire_in_chan.sv
// One wire-in channel: holding register, output register and status flags.
// Latency: write -> hold 1 edge; transfer -> dout 1 edge; changed is 1 edge after transfer.
// Backpressure: none; every hit/update is accepted in the cycle it arrives.
module ok_wire_in_chan
  import ok_wire_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               UPDATE_MODE = OK_UPD_STROBE,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             update,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic             pending,
  output logic             overwrite
);

  logic [WIDTH-1:0] hold;
  logic             xfer;
  logic [WIDTH-1:0] next_out;

  // Select transfer event and value; a write coinciding with an update goes straight through.
  always_comb begin
    xfer     = 1'b0;
    next_out = hold;
    if (UPDATE_MODE == OK_UPD_IMMEDIATE) begin
      xfer     = hit;
      next_out = din;
    end else begin
      xfer     = update;
      next_out = hit ? din : hold;
    end
  end

  // Hold/output registers and status flags; reset discards any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= RESET_VAL;
      dout      <= RESET_VAL;
      changed   <= 1'b0;
      pending   <= 1'b0;
      overwrite <= 1'b0;
    end else begin
      if (hit)  hold <= din;
      if (xfer) dout <= next_out;
      changed <= xfer && (next_out != dout);
      if (UPDATE_MODE == OK_UPD_IMMEDIATE) begin
        pending   <= 1'b0;
        overwrite <= 1'b0;
      end else begin
        if (update)   pending <= 1'b0;
        else if (hit) pending <= 1'b1;
        // A second write before transfer wins over a same-cycle clear.
        if (hit && pending && !update) overwrite <= 1'b1;
        else if (clr)                  overwrite <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ok_wire_in_bank.sv
// Bank of N_CH wire-in channels decoded at BASE_ADDR..BASE_ADDR+N_CH-1.
// Latency: host write -> hold 1 edge; wireupdate (or write in immediate mode) -> ep_dataout 1 edge.
// Backpressure: none; out-of-window writes are silently ignored.
module ok_wire_in_bank
  import ok_wire_pkg::*;
#(
  parameter int                    N_CH        = 4,
  parameter int                    WIDTH       = 32,
  parameter logic [7:0]            BASE_ADDR   = 8'h00,
  parameter int                    UPDATE_MODE = OK_UPD_STROBE,
  parameter logic [N_CH*WIDTH-1:0] RESET_VAL   = '0
) (
  input logic              ti_clk,
  input logic              ti_reset,
  ok_wire_in_bank_if.slave bus
);

  // Reject configurations that fall outside the wire-in address window or bus width.
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("ok_wire_in_bank: N_CH out of range 1..32");
  end
  if (WIDTH < 1 || WIDTH > OK_DATA_W) begin : g_bad_width
    $error("ok_wire_in_bank: WIDTH out of range 1..32");
  end
  if (int'(BASE_ADDR) + N_CH - 1 > int'(OK_WIREIN_ADDR_LAST)) begin : g_bad_addr
    $error("ok_wire_in_bank: channel window exceeds wire-in address range");
  end
  if (UPDATE_MODE != OK_UPD_STROBE && UPDATE_MODE != OK_UPD_IMMEDIATE) begin : g_bad_mode
    $error("ok_wire_in_bank: unknown UPDATE_MODE");
  end

  // Upper data bits beyond WIDTH are intentionally dropped.
  logic unused_datain;
  assign unused_datain = ^bus.ti_datain;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [7:0] CH_ADDR = BASE_ADDR + 8'(i);
    logic hit;
    assign hit = bus.ti_write && (bus.ti_addr == CH_ADDR);

    ok_wire_in_chan #(
      .WIDTH       (WIDTH),
      .UPDATE_MODE (UPDATE_MODE),
      .RESET_VAL   (RESET_VAL[i*WIDTH +: WIDTH])
    ) u_chan (
      .clk       (ti_clk),
      .rst       (ti_reset),
      .hit       (hit),
      .update    (bus.ti_wireupdate),
      .clr       (bus.clr_overwrite),
      .din       (bus.ti_datain[WIDTH-1:0]),
      .dout      (bus.ep_dataout[i*WIDTH +: WIDTH]),
      .changed   (bus.ep_changed[i]),
      .pending   (bus.ep_pending[i]),
      .overwrite (bus.ep_overwrite[i])
    );
  end

endmodule

// File: tb/tb_ok_wire_in_bank.sv
// Directed bench for ok_wire_in_bank: strobe-mode bank at 0x04 and immediate-mode 8-bit bank at 0x10.
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: n/a.
module tb_ok_wire_in_bank;

  localparam logic [127:0] RV0 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
  localparam logic [31:0]  RV1 = 32'h44332211;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ok_wire_in_bank_if #(.N_CH(4), .WIDTH(32)) bus0 ();
  ok_wire_in_bank_if #(.N_CH(4), .WIDTH(8))  bus1 ();

  ok_wire_in_bank #(
    .N_CH(4), .WIDTH(32), .BASE_ADDR(8'h04), .UPDATE_MODE(0), .RESET_VAL(RV0)
  ) dut0 (
    .ti_clk(clk), .ti_reset(rst), .bus(bus0)
  );

  ok_wire_in_bank #(
    .N_CH(4), .WIDTH(8), .BASE_ADDR(8'h10), .UPDATE_MODE(1), .RESET_VAL(RV1)
  ) dut1 (
    .ti_clk(clk), .ti_reset(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.ti_write = 0; bus0.ti_addr = 0; bus0.ti_datain = 0;
    bus0.ti_wireupdate = 0; bus0.clr_overwrite = 0;
    bus1.ti_write = 0; bus1.ti_addr = 0; bus1.ti_datain = 0;
    bus1.ti_wireupdate = 0; bus1.clr_overwrite = 0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_data0", bus0.ep_dataout, RV0);
    chk("rst_data1", bus1.ep_dataout, RV1);
    chk("rst_flags0", {bus0.ep_changed, bus0.ep_pending, bus0.ep_overwrite}, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("rel_changed0", bus0.ep_changed, 0);
    chk("rel_changed1", bus1.ep_changed, 0);
    chk("rel_data0", bus0.ep_dataout, RV0);

    // Out-of-window write (0x00) in strobe mode is ignored
    bus0.ti_write = 1; bus0.ti_addr = 8'h00; bus0.ti_datain = 32'h99999999;
    tick();
    bus0.ti_write = 0;
    chk("oow_pending0", bus0.ep_pending, 4'b0000);

    // Write ch2 (0x06), no update for 10 cycles
    bus0.ti_write = 1; bus0.ti_addr = 8'h06; bus0.ti_datain = 32'h12345678;
    tick();
    bus0.ti_write = 0;
    chk("wr_pending", bus0.ep_pending, 4'b0100);
    for (int i = 0; i < 10; i++) tick();
    chk("wr_noupd_data", bus0.ep_dataout, RV0);
    chk("wr_noupd_pending", bus0.ep_pending, 4'b0100);
    bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_wireupdate = 0;
    chk("upd_data", bus0.ep_dataout, {32'hCAFE0003, 32'h12345678, 32'hCAFE0001, 32'hCAFE0000});
    chk("upd_changed", bus0.ep_changed, 4'b0100);
    chk("upd_pending", bus0.ep_pending, 4'b0000);
    tick();
    chk("upd_changed_pulse", bus0.ep_changed, 4'b0000);

    // Double write to ch1 -> overwrite
    bus0.ti_write = 1; bus0.ti_addr = 8'h05; bus0.ti_datain = 32'hA;
    tick();
    bus0.ti_datain = 32'hB;
    tick();
    bus0.ti_write = 0;
    chk("ow_pending", bus0.ep_pending, 4'b0010);
    chk("ow_flag", bus0.ep_overwrite, 4'b0010);
    bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_wireupdate = 0;
    chk("ow_data", bus0.ep_dataout, {32'hCAFE0003, 32'h12345678, 32'h0000000B, 32'hCAFE0000});
    chk("ow_changed", bus0.ep_changed, 4'b0010);
    tick(); tick(); tick();
    chk("ow_sticky", bus0.ep_overwrite, 4'b0010);
    bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_wireupdate = 0;
    chk("same_upd_changed", bus0.ep_changed, 4'b0000);
    bus0.clr_overwrite = 1;
    tick();
    bus0.clr_overwrite = 0;
    chk("ow_clr", bus0.ep_overwrite, 4'b0000);

    // Set beats clear in the same cycle
    bus0.ti_write = 1; bus0.ti_addr = 8'h05; bus0.ti_datain = 32'hC;
    tick();
    bus0.ti_datain = 32'hB; bus0.clr_overwrite = 1;
    tick();
    bus0.ti_write = 0; bus0.clr_overwrite = 0;
    chk("ow_set_prio", bus0.ep_overwrite, 4'b0010);
    bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_wireupdate = 0;
    chk("prio_changed", bus0.ep_changed, 4'b0000);
    bus0.clr_overwrite = 1;
    tick();
    bus0.clr_overwrite = 0;

    // Write ch0 with simultaneous update: write-through
    bus0.ti_write = 1; bus0.ti_addr = 8'h04; bus0.ti_datain = 32'h55; bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_write = 0; bus0.ti_wireupdate = 0;
    chk("wt_data", bus0.ep_dataout, {32'hCAFE0003, 32'h12345678, 32'h0000000B, 32'h00000055});
    chk("wt_changed", bus0.ep_changed, 4'b0001);
    chk("wt_pending", bus0.ep_pending, 4'b0000);
    chk("wt_overwrite", bus0.ep_overwrite, 4'b0000);

    // Immediate mode, 8-bit, base 0x10
    bus1.ti_write = 1; bus1.ti_addr = 8'h11; bus1.ti_datain = 32'hFFFFFF3C;
    tick();
    bus1.ti_write = 0;
    chk("imm_data", bus1.ep_dataout, 32'h44333C11);
    chk("imm_changed", bus1.ep_changed, 4'b0010);
    bus1.ti_write = 1; bus1.ti_addr = 8'h14; bus1.ti_datain = 32'h99;
    tick();
    bus1.ti_write = 0;
    chk("imm_oow_data", bus1.ep_dataout, 32'h44333C11);
    chk("imm_oow_changed", bus1.ep_changed, 4'b0000);
    bus1.ti_wireupdate = 1;
    tick();
    bus1.ti_wireupdate = 0;
    chk("imm_upd_data", bus1.ep_dataout, 32'h44333C11);
    chk("imm_flags", {bus1.ep_changed, bus1.ep_pending, bus1.ep_overwrite}, 0);

    // Async reset between write and update
    bus0.ti_write = 1; bus0.ti_addr = 8'h07; bus0.ti_datain = 32'hDEADBEEF;
    tick();
    bus0.ti_write = 0;
    chk("pre_rst_pending", bus0.ep_pending, 4'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data0", bus0.ep_dataout, RV0);
    chk("async_rst_data1", bus1.ep_dataout, RV1);
    chk("async_rst_pending", bus0.ep_pending, 4'b0000);
    tick();
    rst = 1'b0;
    tick();
    bus0.ti_wireupdate = 1;
    tick();
    bus0.ti_wireupdate = 0;
    chk("post_rst_upd_data", bus0.ep_dataout, RV0);
    chk("post_rst_changed", bus0.ep_changed, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
